// File: rtl/field_borders_ctrl.sv
// Game-field border renderer with per-side enables and hit-triggered flashing.
// Define FIELD_VERTICAL_BORDERS_EN to render left/right borders as well.
module field_borders_ctrl #(
    parameter int BORDER_WIDTH   = 10,
    parameter int X_LEFT_BORDER  = 19,
    parameter int X_RIGHT_BORDER = 620,
    parameter int Y_UP_BORDER    = 19,
    parameter int Y_DOWN_BORDER  = 460,
    parameter int FLASH_FRAMES   = 8,
    parameter int FLASH_BLINKS   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [10:0] vcount,
    input  logic        blank,
    input  logic [3:0]  side_en,
    input  logic [3:0]  hit,
    output logic        draw_borders,
    output logic [1:0]  border_side,
    output logic [3:0]  flashing
);

`ifdef FIELD_VERTICAL_BORDERS_EN
    localparam logic [3:0] SIDE_MASK = 4'b1111;
`else
    localparam logic [3:0] SIDE_MASK = 4'b0011;
`endif

    localparam logic [10:0] XL = 11'(X_LEFT_BORDER);
    localparam logic [10:0] XR = 11'(X_RIGHT_BORDER);
    localparam logic [10:0] YU = 11'(Y_UP_BORDER);
    localparam logic [10:0] YD = 11'(Y_DOWN_BORDER);
    localparam logic [10:0] TOP_END   = 11'(Y_UP_BORDER + BORDER_WIDTH - 1);
    localparam logic [10:0] BOT_START = 11'(Y_DOWN_BORDER - BORDER_WIDTH + 1);
`ifdef FIELD_VERTICAL_BORDERS_EN
    localparam logic [10:0] LEFT_END    = 11'(X_LEFT_BORDER + BORDER_WIDTH - 1);
    localparam logic [10:0] RIGHT_START = 11'(X_RIGHT_BORDER - BORDER_WIDTH + 1);
`endif
    localparam logic [7:0] FRAME_LAST = 8'(FLASH_FRAMES - 1);
    localparam logic [4:0] TOG_END    = 5'(2 * FLASH_BLINKS);

    typedef enum logic {IDLE, FLASH} state_t;

    logic [3:0] en;
    logic [3:0] hit_ok;
    logic [3:0] region;
    logic [3:0] visible;
    logic [3:0] active;
    logic [3:0] contrib;
    logic       v_nz_q;
    logic       tick_q;
    logic       draw_d;
    logic [1:0] side_d;

    assign en     = side_en & SIDE_MASK;
    assign hit_ok = hit & en;

    always_comb begin
        region    = '0;
        region[0] = (hcount >= XL) && (hcount <= XR) &&
                    (vcount >= YU) && (vcount <= TOP_END);
        region[1] = (hcount >= XL) && (hcount <= XR) &&
                    (vcount >= BOT_START) && (vcount <= YD);
`ifdef FIELD_VERTICAL_BORDERS_EN
        region[2] = (vcount >= YU) && (vcount <= YD) &&
                    (hcount >= XL) && (hcount <= LEFT_END);
        region[3] = (vcount >= YU) && (vcount <= YD) &&
                    (hcount >= RIGHT_START) && (hcount <= XR);
`endif
    end

    // Tick is registered so every side FSM sees the same one-cycle pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_nz_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            v_nz_q <= |vcount;
            tick_q <= (vcount == 11'd0) && v_nz_q;
        end
    end

    for (genvar i = 0; i < 4; i++) begin : g_side
        state_t     state_q, state_d;
        logic [7:0] frame_q, frame_d;
        logic [4:0] tog_q, tog_d;
        logic       vis_q, vis_d;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                state_q <= IDLE;
                frame_q <= '0;
                tog_q   <= '0;
                vis_q   <= 1'b1;
            end else begin
                state_q <= state_d;
                frame_q <= frame_d;
                tog_q   <= tog_d;
                vis_q   <= vis_d;
            end
        end

        always_comb begin
            state_d = state_q;
            frame_d = frame_q;
            tog_d   = tog_q;
            vis_d   = vis_q;
            unique case (state_q)
                IDLE: begin
                    vis_d = 1'b1;
                    if (hit_ok[i]) begin
                        state_d = FLASH;
                        frame_d = '0;
                        tog_d   = '0;
                        vis_d   = 1'b0;
                    end
                end
                FLASH: begin
                    if (!en[i]) begin
                        state_d = IDLE;
                        frame_d = '0;
                        tog_d   = '0;
                        vis_d   = 1'b1;
                    end else if (hit_ok[i]) begin
                        frame_d = '0;
                        tog_d   = '0;
                        vis_d   = 1'b0;
                    end else if (tick_q) begin
                        if (frame_q == FRAME_LAST) begin
                            frame_d = '0;
                            tog_d   = tog_q + 5'd1;
                            vis_d   = !vis_q;
                            if (tog_q + 5'd1 == TOG_END) begin
                                state_d = IDLE;
                                vis_d   = 1'b1;
                            end
                        end else begin
                            frame_d = frame_q + 8'd1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        assign visible[i] = vis_q;
        assign active[i]  = (state_q == FLASH);
    end

    assign contrib = region & en & visible;

    always_comb begin
        draw_d = !blank && (|contrib);
        side_d = 2'd0;
        if (contrib[0])      side_d = 2'd0;
        else if (contrib[1]) side_d = 2'd1;
        else if (contrib[2]) side_d = 2'd2;
        else if (contrib[3]) side_d = 2'd3;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            draw_borders <= 1'b0;
            border_side  <= 2'd0;
        end else begin
            draw_borders <= draw_d;
            border_side  <= side_d;
        end
    end

    assign flashing = active & SIDE_MASK;

endmodule

// File: doc/field_borders_ctrl.md
# field_borders_ctrl

Parametrised game-field border renderer replacing the fixed two-border generator in the video path. Decodes the VGA timing counters into up to four field borders (top, bottom, left, right) with per-side enables, and flashes an individual border for a programmable number of frames when the ball control logic reports a hit on that side. Sits between the VGA timing generator and the pixel colour mux, alongside the ball and paddle controllers.

## Interface
Parameters:
- BORDER_WIDTH, 10: border thickness in pixels (1..63).
- X_LEFT_BORDER, 19: outer left column of the field.
- X_RIGHT_BORDER, 620: outer right column of the field.
- Y_UP_BORDER, 19: outer top row of the field.
- Y_DOWN_BORDER, 460: outer bottom row of the field.
- FLASH_FRAMES, 8: frames per flash half-period (1..255).
- FLASH_BLINKS, 3: invisible/visible cycles per hit (1..15).

Ports:
- clk  input  1  pixel clock; one pixel per cycle.
- reset  input  1  asynchronous, active-low reset.
- hcount  input  11  current column.
- vcount  input  11  current row.
- blank  input  1  high outside the visible area.
- side_en  input  4  per-side enable; bit 0 top, 1 bottom, 2 left, 3 right.
- hit  input  4  one-cycle hit pulses, same bit order.
- draw_borders  output  1  registered draw enable.
- border_side  output  2  registered index of the side being drawn (0 top, 1 bottom, 2 left, 3 right).
- flashing  output  4  per-side flash-in-progress flags.

## Operation
- Side regions (inclusive, 11-bit unsigned compares):
  - top: h in [X_LEFT, X_RIGHT], v in [Y_UP, Y_UP+W-1].
  - bottom: h in [X_LEFT, X_RIGHT], v in [Y_DOWN-W+1, Y_DOWN].
  - left: v in [Y_UP, Y_DOWN], h in [X_LEFT, X_LEFT+W-1].
  - right: v in [Y_UP, Y_DOWN], h in [X_RIGHT-W+1, X_RIGHT].
- A side contributes when it is in region, its side_en bit is 1 and its visible flag is 1.
- draw_borders = !blank AND any side contributes.
- border_side gives the lowest-index contributing side (top > bottom > left > right); 0 when none contribute.
- Frame tick: a one-cycle pulse, generated internally and registered, when vcount changes from nonzero to 0.
- Per-side flash FSM with states IDLE and FLASH. Each side has a frame counter (8 bit), a toggle counter (5 bit) and a visible flag.
  - IDLE: visible=1. A hit on an enabled side moves to FLASH with visible=0 and both counters cleared.
  - FLASH: on each tick the frame counter increments. When it reaches FLASH_FRAMES-1, the tick clears it, toggles visible and increments the toggle counter.
  - When the toggle counter reaches 2*FLASH_BLINKS, the FSM returns to IDLE with visible=1.
  - flashing[i] = (state_i == FLASH).
- A hit on a disabled side is ignored.
- A hit during FLASH restarts the flash.
- A hit and a tick in the same cycle: the hit wins and the tick is discarded for that side.
- Clearing side_en[i] during FLASH aborts the flash to IDLE on the next cycle.

## Timing
- Reset (async assert, sync release): draw_borders=0, border_side=0, flashing=0, all FSMs IDLE with visible=1, frame tick detector cleared.
- draw_borders and border_side: exactly 1 cycle latency from hcount, vcount, blank and side_en.
- flashing[i] rises on the cycle after the hit pulse.
- Flash duration: 2*FLASH_BLINKS*FLASH_FRAMES frame ticks. With the defaults this is 48.
- Reset asserted mid-flash: the flash aborts immediately and the border is visible after release.

## Configuration
- FIELD_VERTICAL_BORDERS_EN defined: all four sides are rendered as specified above.
- FIELD_VERTICAL_BORDERS_EN undefined:
  - left and right regions are compiled out.
  - side_en[3:2] and hit[3:2] are ignored.
  - flashing[3:2] are tied to 0.
  - Only top and bottom are drawn, giving two-border legacy behaviour.

## Test plan
- Defaults, all side_en=1, blank=0. Drive (h,v) = (19,19), (18,19), (19,28), (19,29). Required draw_borders one cycle later: 1, 0, 1, 0; border_side=0 on the hits.
- Macro defined. (19,200) gives draw 1, side 2. (620,200) gives draw 1, side 3. (29,200) gives 0. Macro undefined: (19,200) gives 0.
- Bottom and blanking: (300,451) and (300,460) give 1 with side 1. (300,450) gives 0. (300,460) with blank=1 gives 0.
- Flash: pulse hit[0] with side_en[0]=1.
  - flashing[0]=1 next cycle.
  - Top row is not drawn for 8 ticks, then drawn for 8 ticks, repeated 3 times.
  - flashing[0]=0 after tick 48. A second hit at tick 20 restarts the 48-tick count.
- Edge cases:
  - hit[1] with side_en[1]=0 gives flashing[1]=0.
  - hit and tick in the same cycle: frame counter stays 0.
  - reset low at tick 10 of a flash: all outputs 0 immediately, and top is drawn in the first frame after release.
